// File: rtl/median_filter_pkg.sv
// Shared constants and FSM state type for the histogram median finder.
package median_filter_pkg;

    localparam int unsigned IMWIDTH  = 240;
    localparam int unsigned IMHEIGHT = 180;
    localparam int unsigned BINW     = 8;
    localparam int unsigned SUMW     = 16;

    typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} medianState_t;

endpackage

// File: rtl/median_scan_channel.sv
// One histogram axis: captures NBINS bins, then walks them to find the median index.
// Peak tracking is present only when MEDIAN_PEAK_EN is defined; otherwise peak is tied to 0.
module median_scan_channel
    import median_filter_pkg::*;
#(
    parameter int unsigned NBINS = IMWIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            capture,
    input  logic            binValid,
    input  logic [BINW-1:0] binIn,
    input  logic            scanEn,
    input  logic [7:0]      scanIdx,
    output logic            fullNext,
    output logic [7:0]      medianNext,
    output logic            empty,
    output logic [7:0]      peak
);

    localparam int unsigned CW = $clog2(NBINS + 1);

    logic [BINW-1:0] bufQ [NBINS];
    logic [CW-1:0]   cntQ, cntD;
    logic [SUMW-1:0] totalQ, totalD, cumQ, cumD, cumSum;
    logic            foundQ, foundD;
    logic [7:0]      medianQ;
    logic            accept, inRange, hit;
    logic [BINW-1:0] scanBin;

    always_comb begin
        accept     = capture && binValid && (cntQ != CW'(NBINS));
        inRange    = scanEn && (32'(scanIdx) < NBINS);
        scanBin    = inRange ? bufQ[scanIdx] : '0;
        cntD       = clear ? '0 : (accept ? cntQ + 1'b1 : cntQ);
        totalD     = clear ? '0 : (accept ? totalQ + SUMW'(binIn) : totalQ);
        cumSum     = cumQ + SUMW'(scanBin);
        // 17-bit compare so 2*cum never wraps
        hit        = inRange && ({cumSum, 1'b0} >= {1'b0, totalQ});
        cumD       = clear ? '0 : (inRange ? cumSum : cumQ);
        foundD     = !clear && (foundQ || hit);
        medianNext = (hit && !foundQ) ? scanIdx : medianQ;
        fullNext   = (cntD == CW'(NBINS));
        empty      = (totalQ == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBINS; i++) bufQ[i] <= '0;
            cntQ    <= '0;
            totalQ  <= '0;
            cumQ    <= '0;
            foundQ  <= 1'b0;
            medianQ <= '0;
        end else begin
            if (accept) bufQ[cntQ] <= binIn;
            cntQ    <= cntD;
            totalQ  <= totalD;
            cumQ    <= cumD;
            foundQ  <= foundD;
            medianQ <= clear ? '0 : medianNext;
        end
    end

`ifdef MEDIAN_PEAK_EN
    logic [BINW-1:0] maxQ;
    logic [7:0]      peakQ;

    // Strict > keeps the lowest index on ties
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            maxQ  <= '0;
            peakQ <= '0;
        end else if (clear) begin
            maxQ  <= '0;
            peakQ <= '0;
        end else if (accept && (binIn > maxQ)) begin
            maxQ  <= binIn;
            peakQ <= 8'(cntQ);
        end
    end

    assign peak = peakQ;
`else
    assign peak = '0;
`endif

endmodule

// File: rtl/histogram_median_finder.sv
// Captures x/y projection histograms and reports each axis median with a one-cycle valid pulse.
// Optional argmax reporting is enabled by defining MEDIAN_PEAK_EN.
module histogram_median_finder
    import median_filter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            startMedian,
    input  logic [BINW-1:0] xHistogramIn,
    input  logic            xValid,
    input  logic [BINW-1:0] yHistogramIn,
    input  logic            yValid,
    output logic [7:0]      xMedian,
    output logic [7:0]      yMedian,
    output logic            xEmpty,
    output logic            yEmpty,
    output logic            medianValid,
    output logic [7:0]      xPeak,
    output logic [7:0]      yPeak,
    output logic            ready
);

    medianState_t stateQ, stateD;
    logic [7:0]   scanIdxQ;
    logic         clear, capture, scanEn, scanLast;
    logic         xFullNext, yFullNext, xEmptyCh, yEmptyCh;
    logic [7:0]   xMedianNext, yMedianNext, xPeakCh, yPeakCh;

    assign scanLast = (scanIdxQ == 8'(IMWIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE:    if (startMedian) stateD = CAPTURE;
            CAPTURE: if (xFullNext && yFullNext) stateD = SCAN;
            SCAN:    if (scanLast) stateD = DONE;
            DONE:    stateD = IDLE;
        endcase
    end

    always_comb begin
        ready       = (stateQ == IDLE);
        medianValid = (stateQ == DONE);
        clear       = (stateQ == IDLE) && startMedian;
        capture     = (stateQ == CAPTURE);
        scanEn      = (stateQ == SCAN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) scanIdxQ <= '0;
        else        scanIdxQ <= (scanEn && !scanLast) ? scanIdxQ + 8'd1 : '0;
    end

    // Results are loaded on the final scan edge so they are stable while medianValid is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xMedian <= '0;
            yMedian <= '0;
            xEmpty  <= 1'b0;
            yEmpty  <= 1'b0;
            xPeak   <= '0;
            yPeak   <= '0;
        end else if (scanEn && scanLast) begin
            xMedian <= xMedianNext;
            yMedian <= yMedianNext;
            xEmpty  <= xEmptyCh;
            yEmpty  <= yEmptyCh;
            xPeak   <= xPeakCh;
            yPeak   <= yPeakCh;
        end
    end

    median_scan_channel #(.NBINS(IMWIDTH)) xChannel (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .capture    (capture),
        .binValid   (xValid),
        .binIn      (xHistogramIn),
        .scanEn     (scanEn),
        .scanIdx    (scanIdxQ),
        .fullNext   (xFullNext),
        .medianNext (xMedianNext),
        .empty      (xEmptyCh),
        .peak       (xPeakCh)
    );

    median_scan_channel #(.NBINS(IMHEIGHT)) yChannel (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .capture    (capture),
        .binValid   (yValid),
        .binIn      (yHistogramIn),
        .scanEn     (scanEn),
        .scanIdx    (scanIdxQ),
        .fullNext   (yFullNext),
        .medianNext (yMedianNext),
        .empty      (yEmptyCh),
        .peak       (yPeakCh)
    );

endmodule

// File: tb/tb_histogram_median_finder.sv
// Directed bench for histogram_median_finder; expected medians are hand-computed per case.
module tb_histogram_median_finder;
    import median_filter_pkg::*;

`ifdef MEDIAN_PEAK_EN
    localparam bit PeakEn = 1'b1;
`else
    localparam bit PeakEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       startMedian;
    logic [7:0] xHistogramIn, yHistogramIn;
    logic       xValid, yValid;
    logic [7:0] xMedian, yMedian, xPeak, yPeak;
    logic       xEmpty, yEmpty, medianValid, ready;

    int checks   = 0;
    int failures = 0;
    int caseId   = 0;

    logic [7:0] xBins [IMWIDTH];
    logic [7:0] yBins [IMHEIGHT];

    histogram_median_finder dut (
        .clk          (clk),
        .reset        (reset),
        .startMedian  (startMedian),
        .xHistogramIn (xHistogramIn),
        .xValid       (xValid),
        .yHistogramIn (yHistogramIn),
        .yValid       (yValid),
        .xMedian      (xMedian),
        .yMedian      (yMedian),
        .xEmpty       (xEmpty),
        .yEmpty       (yEmpty),
        .medianValid  (medianValid),
        .xPeak        (xPeak),
        .yPeak        (yPeak),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL case%0d %s: got %0d expected %0d", caseId, tag, got, exp);
        end
    endtask

    task automatic fillBins(input logic [7:0] xv, input logic [7:0] yv);
        for (int i = 0; i < IMWIDTH; i++) xBins[i] = xv;
        for (int i = 0; i < IMHEIGHT; i++) yBins[i] = yv;
    endtask

    task automatic driveBeat(input int c, input int yStart, input int yExtra);
        int yIdx;
        xValid       = 1'b1;
        xHistogramIn = xBins[c];
        yIdx         = c - yStart;
        if (yIdx >= 0 && yIdx < IMHEIGHT + yExtra) begin
            yValid       = 1'b1;
            yHistogramIn = (yIdx < IMHEIGHT) ? yBins[yIdx] : 8'hFF;
        end else begin
            yValid       = 1'b0;
            yHistogramIn = 8'h00;
        end
    endtask

    task automatic runCase(input int expXMed, input int expYMed, input int expXE, input int expYE,
                           input int expXP, input int expYP, input int yStart, input int yExtra,
                           input bit pokeStart);
        int lat;
        int extra;
        @(negedge clk) startMedian = 1'b1;
        @(negedge clk) startMedian = 1'b0;
        for (int c = 0; c < IMWIDTH; c++) begin
            driveBeat(c, yStart, yExtra);
            @(negedge clk);
        end
        xValid = 1'b0;
        yValid = 1'b0;
        // Now one negedge after the edge that accepted the last x bin
        lat = 1;
        while (!medianValid && lat < 400) begin
            @(negedge clk);
            lat++;
            startMedian = pokeStart && (lat == 50);
        end
        startMedian = 1'b0;
        checkValue("latency", lat, IMWIDTH + 1);
        checkValue("medianValid", 32'(medianValid), 1);
        checkValue("xMedian", 32'(xMedian), expXMed);
        checkValue("yMedian", 32'(yMedian), expYMed);
        checkValue("xEmpty", 32'(xEmpty), expXE);
        checkValue("yEmpty", 32'(yEmpty), expYE);
        checkValue("xPeak", 32'(xPeak), expXP);
        checkValue("yPeak", 32'(yPeak), expYP);
        @(negedge clk);
        checkValue("validPulseWidth", 32'(medianValid), 0);
        checkValue("readyAfterDone", 32'(ready), 1);
        if (pokeStart) begin
            extra = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (medianValid) extra++;
            end
            checkValue("extraValidPulses", extra, 0);
            checkValue("readyIdle", 32'(ready), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        startMedian  = 1'b0;
        xValid       = 1'b0;
        yValid       = 1'b0;
        xHistogramIn = '0;
        yHistogramIn = '0;
        #2;
        checkValue("resetReady", 32'(ready), 1);
        checkValue("resetValid", 32'(medianValid), 0);
        checkValue("resetXMedian", 32'(xMedian), 0);
        checkValue("resetYEmpty", 32'(yEmpty), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        caseId = 1;
        fillBins(8'd1, 8'd1);
        runCase(119, 89, 0, 0, 0, 0, 0, 0, 1'b0);

        caseId = 2;
        fillBins(8'd0, 8'd0);
        xBins[37]  = 8'd5;
        yBins[150] = 8'd200;
        runCase(37, 150, 0, 0, PeakEn ? 37 : 0, PeakEn ? 150 : 0, 0, 0, 1'b0);

        caseId = 3;
        fillBins(8'd0, 8'd0);
        xBins[10] = 8'd1;
        xBins[20] = 8'd1;
        xBins[30] = 8'd1;
        runCase(20, 0, 0, 1, PeakEn ? 10 : 0, 0, 0, 0, 1'b0);

        caseId = 4;
        fillBins(8'd1, 8'd1);
        runCase(119, 89, 0, 0, 0, 0, 10, 20, 1'b0);

        caseId = 5;
        runCase(119, 89, 0, 0, 0, 0, 0, 0, 1'b1);

        caseId = 6;
        fillBins(8'd3, 8'd3);
        @(negedge clk) startMedian = 1'b1;
        @(negedge clk) startMedian = 1'b0;
        for (int c = 0; c <= 100; c++) begin
            driveBeat(c, 0, 0);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        checkValue("midResetReady", 32'(ready), 1);
        checkValue("midResetValid", 32'(medianValid), 0);
        checkValue("midResetXMedian", 32'(xMedian), 0);
        checkValue("midResetYMedian", 32'(yMedian), 0);
        xValid = 1'b0;
        yValid = 1'b0;
        @(negedge clk) reset = 1'b1;
        fillBins(8'd0, 8'd0);
        xBins[37]  = 8'd5;
        yBins[150] = 8'd200;
        runCase(37, 150, 0, 0, PeakEn ? 37 : 0, PeakEn ? 150 : 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
